mem_access_multi: RTL and testbench

- Memory access unit between the multicycle control FSM/datapath and the unified instruction/data memory.
- On a single-cycle request it:
  - selects the PC or the ALU result as the address;
  - issues one word-aligned bus transaction with byte enables;
  - waits a variable number of cycles for acknowledge;
  - returns sign/zero-extended load data with a done pulse.
- The control FSM holds its memory state while oBusy is high.
- Misaligned accesses, illegal funct3 and bus timeouts are flagged.

---
 rtl/mem_access_multi.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_access_multi.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_multi.sv
// Memory access unit for the multicycle core: one word-aligned bus transaction per request,
// with byte enables, lane-replicated stores, extended loads, legality checks and a bus timeout.
module mem_access_multi #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iReq,
    input  logic        iWrite,
    input  logic        iIouD,
    input  logic [2:0]  iFunct3,
    input  logic [31:0] iPC,
    input  logic [31:0] iALUAddr,
    input  logic [31:0] iWriteData,
    output logic        oMemReq,
    output logic        oMemWE,
    output logic [31:0] oMemAddr,
    output logic [3:0]  oMemBE,
    output logic [31:0] oMemWData,
    input  logic [31:0] iMemRData,
    input  logic        iMemAck,
    output logic [31:0] oReadData,
    output logic        oDone,
    output logic        oErr,
    output logic [1:0]  oErrCode,
    output logic        oBusy
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } state_e;

    localparam logic [1:0] CodeNone     = 2'b00;
    localparam logic [1:0] CodeMisalign = 2'b01;
    localparam logic [1:0] CodeIllegal  = 2'b10;
    localparam logic [1:0] CodeTimeout  = 2'b11;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic [1:0]       off_q, off_d;
    logic [2:0]       f3_q, f3_d;
    logic             load_q, load_d;

    // Request decode, valid only while IDLE samples iReq.
    logic [31:0] req_addr;
    logic [2:0]  req_f3;
    logic        req_we;
    logic        req_illegal;
    logic        req_misal;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;

    always_comb begin
        req_addr    = iIouD ? iALUAddr : iPC;
        req_f3      = iIouD ? iFunct3 : 3'b010;
        req_we      = iIouD & iWrite;
        req_illegal = iIouD & ((iFunct3 == 3'b011) || (iFunct3[2:1] == 2'b11) ||
                               (iFunct3[2] & iWrite));
        req_misal   = 1'b0;
        req_be      = 4'b1111;
        req_wdata   = iWriteData;
        unique case (req_f3[1:0])
            2'b00: begin
                req_be    = 4'b0001 << req_addr[1:0];
                req_wdata = {4{iWriteData[7:0]}};
            end
            2'b01: begin
                req_misal = req_addr[0];
                req_be    = 4'b0011 << {req_addr[1], 1'b0};
                req_wdata = {2{iWriteData[15:0]}};
            end
            default: begin
                req_misal = (req_addr[1:0] != 2'b00);
            end
        endcase
    end

    // Load extraction from the lane selected by the latched byte offset.
    logic [31:0] lane;
    logic [31:0] load_ext;

    always_comb begin
        lane = iMemRData >> {off_q, 3'b000};
        unique case (f3_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'h0, lane[7:0]};
            3'b101:  load_ext = {16'h0, lane[15:0]};
            default: load_ext = iMemRData;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        err_d       = err_q;
        code_d      = code_q;
        off_d       = off_q;
        f3_d        = f3_q;
        load_d      = load_q;

        unique case (state_q)
            StIdle: begin
                err_d  = 1'b0;
                code_d = CodeNone;
                if (iReq) begin
                    if (req_illegal || req_misal) begin
                        // Illegal funct3 takes priority over misalignment.
                        state_d = StDone;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        code_d  = req_illegal ? CodeIllegal : CodeMisalign;
                    end else begin
                        state_d     = StReq;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_be_d    = req_be;
                        mem_wdata_d = req_wdata;
                        off_d       = req_addr[1:0];
                        f3_d        = req_f3;
                        load_d      = ~req_we;
                    end
                end
            end
            StReq: begin
                if (iMemAck) begin
                    state_d   = StDone;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (load_q) begin
                        rdata_d = load_ext;
                    end
                end else if (cnt_q == CntLast) begin
                    state_d   = StDone;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    code_d    = CodeTimeout;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
                err_d   = 1'b0;
                code_d  = CodeNone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= CodeNone;
            off_q       <= '0;
            f3_q        <= '0;
            load_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            code_q      <= code_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
            load_q      <= load_d;
        end
    end

    assign oMemReq   = mem_req_q;
    assign oMemWE    = mem_we_q;
    assign oMemAddr  = mem_addr_q;
    assign oMemBE    = mem_be_q;
    assign oMemWData = mem_wdata_q;
    assign oReadData = rdata_q;
    assign oDone     = done_q;
    assign oErr      = err_q;
    assign oErrCode  = code_q;
    assign oBusy     = (state_q != StIdle);

endmodule

// File: tb/tb_mem_access_multi.sv
// Bench for mem_access_multi: scenario tasks drive requests and push expected completions;
// a completion monitor pops and compares them whenever oDone is seen.
module tb_mem_access_multi;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic        iReq = 1'b0;
    logic        iWrite = 1'b0;
    logic        iIouD = 1'b0;
    logic [2:0]  iFunct3 = 3'b000;
    logic [31:0] iPC = '0;
    logic [31:0] iALUAddr = '0;
    logic [31:0] iWriteData = '0;
    logic        oMemReq;
    logic        oMemWE;
    logic [31:0] oMemAddr;
    logic [3:0]  oMemBE;
    logic [31:0] oMemWData;
    logic [31:0] iMemRData = '0;
    logic        iMemAck = 1'b0;
    logic [31:0] oReadData;
    logic        oDone;
    logic        oErr;
    logic [1:0]  oErrCode;
    logic        oBusy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        err;
        logic [1:0]  code;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_rd = '0;

    mem_access_multi #(
        .TIMEOUT(4),
        .CNT_W  (16)
    ) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iReq      (iReq),
        .iWrite    (iWrite),
        .iIouD     (iIouD),
        .iFunct3   (iFunct3),
        .iPC       (iPC),
        .iALUAddr  (iALUAddr),
        .iWriteData(iWriteData),
        .oMemReq   (oMemReq),
        .oMemWE    (oMemWE),
        .oMemAddr  (oMemAddr),
        .oMemBE    (oMemBE),
        .oMemWData (oMemWData),
        .iMemRData (iMemRData),
        .iMemAck   (iMemAck),
        .oReadData (oReadData),
        .oDone     (oDone),
        .oErr      (oErr),
        .oErrCode  (oErrCode),
        .oBusy     (oBusy)
    );

    always #5 iCLK = ~iCLK;

    // Completion monitor: every oDone must match the oldest pushed expectation.
    always @(negedge iCLK) begin
        if (oDone === 1'b1) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got oDone=1 err=%b code=%b, required no completion",
                         oErr, oErrCode);
            end else begin
                e = sb.pop_front();
                if ({oErr, oErrCode, oReadData} !== {e.err, e.code, e.rd}) begin
                    errors++;
                    $display("FAIL done_result: got err=%b code=%b rd=%h, required err=%b code=%b rd=%h",
                             oErr, oErrCode, oReadData, e.err, e.code, e.rd);
                end
            end
        end
    end

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    // Pulses iReq for cycle 0; returns #1 into cycle 1.
    task automatic issue(input logic w, input logic iou, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd);
        iWrite     = w;
        iIouD      = iou;
        iFunct3    = f3;
        iPC        = pc;
        iALUAddr   = alu;
        iWriteData = wd;
        iReq       = 1'b1;
        step();
        iReq = 1'b0;
    endtask

    task automatic ack(input logic [31:0] d);
        iMemAck   = 1'b1;
        iMemRData = d;
        step();
        iMemAck = 1'b0;
    endtask

    task automatic test_reset();
        iRST = 1'b0;
        step();
        step();
        checks++;
        if ({oMemReq, oMemWE, oMemAddr, oMemBE, oMemWData} !== 70'h0) begin
            errors++;
            $display("FAIL reset_bus: got req=%b we=%b addr=%h be=%b wd=%h, required all 0",
                     oMemReq, oMemWE, oMemAddr, oMemBE, oMemWData);
        end
        checks++;
        if ({oReadData, oDone, oErr, oErrCode, oBusy} !== 37'h0) begin
            errors++;
            $display("FAIL reset_status: got rd=%h done=%b err=%b code=%b busy=%b, required all 0",
                     oReadData, oDone, oErr, oErrCode, oBusy);
        end
        iRST = 1'b1;
        step();
    endtask

    task automatic test_fetch();
        sb.push_back('{err: 1'b0, code: 2'b00, rd: 32'h0051_0113});
        last_rd = 32'h0051_0113;
        issue(1'b0, 1'b0, 3'b111, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if ({oMemReq, oMemWE, oMemAddr, oMemBE, oBusy} !== {1'b1, 1'b0, 32'h10, 4'hF, 1'b1}) begin
                errors++;
                $display("FAIL fetch_bus c%0d: got req=%b we=%b addr=%h be=%b busy=%b, required 1 0 00000010 1111 1",
                         c, oMemReq, oMemWE, oMemAddr, oMemBE, oBusy);
            end
            if (c < 3) step();
        end
        ack(32'h0051_0113);
        checks++;
        if ({oDone, oMemReq} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_done: got done=%b req=%b at cycle 4, required done=1 req=0",
                     oDone, oMemReq);
        end
        step();
        checks++;
        if ({oDone, oBusy} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_idle: got done=%b busy=%b, required 0 0", oDone, oBusy);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  tf3[7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b000};
        logic [31:0] tad[7] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100, 32'h101};
        logic [3:0]  tbe[7] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1111, 4'b0001, 4'b0010};
        logic [31:0] trd[7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF,
                                32'h80FF_1234, 32'h0000_0034, 32'h0000_0012};
        for (int i = 0; i < 7; i++) begin
            sb.push_back('{err: 1'b0, code: 2'b00, rd: trd[i]});
            last_rd = trd[i];
            issue(1'b0, 1'b1, tf3[i], 32'h0, tad[i], 32'h0);
            checks++;
            if ({oMemReq, oMemWE, oMemAddr, oMemBE} !== {1'b1, 1'b0, 32'h100, tbe[i]}) begin
                errors++;
                $display("FAIL load_bus #%0d: got req=%b we=%b addr=%h be=%b, required 1 0 00000100 %b",
                         i, oMemReq, oMemWE, oMemAddr, oMemBE, tbe[i]);
            end
            ack(32'h80FF_1234);
            step();
        end
    endtask

    task automatic test_store();
        sb.push_back('{err: 1'b0, code: 2'b00, rd: last_rd});
        issue(1'b1, 1'b1, 3'b001, 32'h0, 32'h206, 32'hDEAD_BEEF);
        checks++;
        if ({oMemReq, oMemWE, oMemAddr, oMemBE, oMemWData} !==
            {1'b1, 1'b1, 32'h204, 4'b1100, 32'hBEEF_BEEF}) begin
            errors++;
            $display("FAIL store_bus: got req=%b we=%b addr=%h be=%b wd=%h, required 1 1 00000204 1100 beefbeef",
                     oMemReq, oMemWE, oMemAddr, oMemBE, oMemWData);
        end
        step();
        ack(32'h1234_5678);
        step();
        // Byte store replication.
        sb.push_back('{err: 1'b0, code: 2'b00, rd: last_rd});
        issue(1'b1, 1'b1, 3'b000, 32'h0, 32'h301, 32'h0000_00A5);
        checks++;
        if ({oMemBE, oMemWData} !== {4'b0010, 32'hA5A5_A5A5}) begin
            errors++;
            $display("FAIL sb_bus: got be=%b wd=%h, required 0010 a5a5a5a5", oMemBE, oMemWData);
        end
        ack(32'hFFFF_FFFF);
        step();
    endtask

    task automatic test_errors();
        logic        tw[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        tio[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0]  tf3[5] = '{3'b010, 3'b011, 3'b100, 3'b010, 3'b111};
        logic [31:0] tad[5] = '{32'h101, 32'h100, 32'h100, 32'h102, 32'h101};
        logic [1:0]  tcd[5] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b10};
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{err: 1'b1, code: tcd[i], rd: last_rd});
            issue(tw[i], tio[i], tf3[i], tad[i], tad[i], 32'h5555_5555);
            checks++;
            if ({oDone, oMemReq, oMemWE} !== 3'b100) begin
                errors++;
                $display("FAIL err_path #%0d: got done=%b req=%b we=%b at cycle 1, required 1 0 0",
                         i, oDone, oMemReq, oMemWE);
            end
            step();
            checks++;
            if ({oBusy, oMemReq} !== 2'b00) begin
                errors++;
                $display("FAIL err_idle #%0d: got busy=%b req=%b, required 0 0", i, oBusy, oMemReq);
            end
        end
    endtask

    task automatic test_timeout();
        sb.push_back('{err: 1'b1, code: 2'b11, rd: last_rd});
        issue(1'b0, 1'b1, 3'b010, 32'h0, 32'h400, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if ({oMemReq, oDone} !== 2'b10) begin
                errors++;
                $display("FAIL timeout_req c%0d: got req=%b done=%b, required 1 0", c, oMemReq, oDone);
            end
            step();
        end
        checks++;
        if ({oDone, oMemReq} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_done: got done=%b req=%b at cycle 5, required 1 0", oDone, oMemReq);
        end
        step();
        checks++;
        if (oBusy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: got busy=%b, required 0", oBusy);
        end
        // Ack on the final count wins over the timeout.
        sb.push_back('{err: 1'b0, code: 2'b00, rd: 32'hCAFE_0001});
        last_rd = 32'hCAFE_0001;
        issue(1'b0, 1'b1, 3'b010, 32'h0, 32'h400, 32'h0);
        step();
        step();
        step();
        ack(32'hCAFE_0001);
        checks++;
        if (oDone !== 1'b1) begin
            errors++;
            $display("FAIL ack_last_count: got done=%b at cycle 5, required 1", oDone);
        end
        step();
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 1'b1, 3'b010, 32'h0, 32'h500, 32'h0);
        step();
        iRST = 1'b0;
        step();
        iRST = 1'b1;
        last_rd = 32'h0;
        checks++;
        if ({oMemReq, oMemWE, oMemAddr, oMemBE, oMemWData, oReadData, oDone, oErr, oErrCode, oBusy}
            !== 107'h0) begin
            errors++;
            $display("FAIL reset_mid: got req=%b addr=%h be=%b rd=%h busy=%b, required all 0",
                     oMemReq, oMemAddr, oMemBE, oReadData, oBusy);
        end
        ack(32'hBAD0_BAD0);
        checks++;
        if ({oDone, oBusy} !== 2'b00) begin
            errors++;
            $display("FAIL late_ack: got done=%b busy=%b, required 0 0", oDone, oBusy);
        end
        sb.push_back('{err: 1'b0, code: 2'b00, rd: 32'hFFFF_FF9A});
        last_rd = 32'hFFFF_FF9A;
        issue(1'b0, 1'b1, 3'b000, 32'h0, 32'h502, 32'h0);
        ack(32'h009A_0000);
        step();
    endtask

    task automatic test_back_to_back();
        sb.push_back('{err: 1'b0, code: 2'b00, rd: 32'h0000_7777});
        last_rd = 32'h0000_7777;
        issue(1'b0, 1'b1, 3'b101, 32'h0, 32'h600, 32'h0);
        // Second request while busy must be ignored.
        iALUAddr = 32'h700;
        iFunct3  = 3'b010;
        iReq     = 1'b1;
        step();
        iReq = 1'b0;
        checks++;
        if ({oMemAddr, oMemBE} !== {32'h600, 4'b0011}) begin
            errors++;
            $display("FAIL busy_ignore: got addr=%h be=%b, required 00000600 0011", oMemAddr, oMemBE);
        end
        ack(32'h1111_7777);
        step();
        step();
        step();
        checks++;
        if (oBusy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got busy=%b, required 0", oBusy);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_loads();
        test_store();
        test_errors();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d completions outstanding, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
